// File: rtl/param_ds_alu.sv
// Parametrised data stack with an in-place ALU execute path.
// Entries live in a register array addressed by the stack size; TOS/NOS are read through registered indices.
module param_ds_alu #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 128,
  localparam int SW = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             async_reset,
  input  logic             op_valid,
  input  logic [2:0]       ds_op,
  input  logic [2:0]       alu_op,
  input  logic [WIDTH-1:0] ds_data,
  input  logic             clr_err,
  output logic [WIDTH-1:0] tos_out,
  output logic [WIDTH-1:0] nos_out,
  output logic [SW-1:0]    ds_size,
  output logic             full,
  output logic             empty,
  output logic             stack_overflow,
  output logic             stack_underflow,
  output logic [3:0]       status
);

  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {
    DS_NOP   = 3'd0,
    DS_PUSH  = 3'd1,
    DS_POP   = 3'd2,
    DS_WRITE = 3'd3,
    DS_DUP   = 3'd4,
    DS_SWAP  = 3'd5,
    DS_OVER  = 3'd6,
    DS_ALU   = 3'd7
  } ds_op_e;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_XOR  = 3'd4,
    ALU_NOT  = 3'd5,
    ALU_SHL1 = 3'd6,
    ALU_SHR1 = 3'd7
  } alu_op_e;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [SW-1:0]    size_q, size_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [3:0]       status_q, status_d;

  logic [AW-1:0]    tos_idx, nos_idx, push_idx;
  logic [WIDTH-1:0] tos_rd, nos_rd;
  logic             is_empty, is_full, has_two;

  logic             wr0_en, wr1_en;
  logic [AW-1:0]    wr0_addr, wr1_addr;
  logic [WIDTH-1:0] wr0_data, wr1_data;

  logic [WIDTH:0]   sum_w, diff_w;
  logic [WIDTH-1:0] alu_res;
  logic             alu_c, alu_v;
  logic             alu_binary;
  logic [3:0]       alu_status;

  // Indices depend only on size_q, so the read muxes never see ds_op.
  assign tos_idx  = AW'(size_q - SW'(1));
  assign nos_idx  = AW'(size_q - SW'(2));
  assign push_idx = AW'(size_q);

  assign is_empty = (size_q == '0);
  assign is_full  = (size_q == SW'(DEPTH));
  assign has_two  = (size_q >= SW'(2));

  assign tos_rd = mem_q[tos_idx];
  assign nos_rd = mem_q[nos_idx];

  always_comb begin
    sum_w   = {1'b0, nos_rd} + {1'b0, tos_rd};
    diff_w  = {1'b0, nos_rd} - {1'b0, tos_rd};
    alu_res = '0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    case (alu_op_e'(alu_op))
      ALU_ADD: begin
        alu_res = sum_w[WIDTH-1:0];
        alu_c   = sum_w[WIDTH];
        alu_v   = (nos_rd[WIDTH-1] == tos_rd[WIDTH-1]) && (alu_res[WIDTH-1] != nos_rd[WIDTH-1]);
      end
      ALU_SUB: begin
        // Bit WIDTH of the zero-extended difference is the borrow (NOS < TOS).
        alu_res = diff_w[WIDTH-1:0];
        alu_c   = diff_w[WIDTH];
        alu_v   = (nos_rd[WIDTH-1] != tos_rd[WIDTH-1]) && (alu_res[WIDTH-1] != nos_rd[WIDTH-1]);
      end
      ALU_AND:  alu_res = nos_rd & tos_rd;
      ALU_OR:   alu_res = nos_rd | tos_rd;
      ALU_XOR:  alu_res = nos_rd ^ tos_rd;
      ALU_NOT:  alu_res = ~tos_rd;
      ALU_SHL1: begin
        alu_res = {tos_rd[WIDTH-2:0], 1'b0};
        alu_c   = tos_rd[WIDTH-1];
      end
      ALU_SHR1: begin
        alu_res = {1'b0, tos_rd[WIDTH-1:1]};
        alu_c   = tos_rd[0];
      end
      default: alu_res = '0;
    endcase
  end

  assign alu_binary = (alu_op < 3'd5);
  assign alu_status = {alu_res[WIDTH-1], (alu_res == '0), alu_c, alu_v};

  always_comb begin
    wr0_en   = 1'b0;
    wr0_addr = tos_idx;
    wr0_data = ds_data;
    wr1_en   = 1'b0;
    wr1_addr = nos_idx;
    wr1_data = tos_rd;
    size_d   = size_q;
    status_d = status_q;
    // A fresh error below overrides the clear in the same cycle.
    ovf_d    = clr_err ? 1'b0 : ovf_q;
    unf_d    = clr_err ? 1'b0 : unf_q;

    if (op_valid) begin
      case (ds_op_e'(ds_op))
        DS_PUSH: begin
          if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_addr = push_idx;
            wr0_data = ds_data;
            size_d   = size_q + SW'(1);
          end
        end
        DS_POP: begin
          if (is_empty) unf_d = 1'b1;
          else          size_d = size_q - SW'(1);
        end
        DS_WRITE: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_addr = tos_idx;
            wr0_data = ds_data;
          end
        end
        DS_DUP: begin
          if (is_empty) begin
            unf_d = 1'b1;
          end else if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_addr = push_idx;
            wr0_data = tos_rd;
            size_d   = size_q + SW'(1);
          end
        end
        DS_SWAP: begin
          if (!has_two) begin
            unf_d = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_addr = tos_idx;
            wr0_data = nos_rd;
            wr1_en   = 1'b1;
            wr1_addr = nos_idx;
            wr1_data = tos_rd;
          end
        end
        DS_OVER: begin
          if (!has_two) begin
            unf_d = 1'b1;
          end else if (is_full) begin
            ovf_d = 1'b1;
          end else begin
            wr0_en   = 1'b1;
            wr0_addr = push_idx;
            wr0_data = nos_rd;
            size_d   = size_q + SW'(1);
          end
        end
        DS_ALU: begin
          if (alu_binary) begin
            if (!has_two) begin
              unf_d = 1'b1;
            end else begin
              wr0_en   = 1'b1;
              wr0_addr = nos_idx;
              wr0_data = alu_res;
              size_d   = size_q - SW'(1);
              status_d = alu_status;
            end
          end else begin
            if (is_empty) begin
              unf_d = 1'b1;
            end else begin
              wr0_en   = 1'b1;
              wr0_addr = tos_idx;
              wr0_data = alu_res;
              status_d = alu_status;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or posedge async_reset) begin
    if (async_reset) begin
      size_q   <= '0;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
      status_q <= '0;
    end else begin
      size_q   <= size_d;
      ovf_q    <= ovf_d;
      unf_q    <= unf_d;
      status_q <= status_d;
    end
  end

  for (genvar gi = 0; gi < DEPTH; gi++) begin : g_entry
    always_ff @(posedge clk or posedge async_reset) begin
      if (async_reset) begin
        mem_q[gi] <= '0;
      end else if (wr0_en && (wr0_addr == AW'(gi))) begin
        mem_q[gi] <= wr0_data;
      end else if (wr1_en && (wr1_addr == AW'(gi))) begin
        mem_q[gi] <= wr1_data;
      end
    end
  end

  assign tos_out         = is_empty ? '0 : tos_rd;
  assign nos_out         = has_two ? nos_rd : '0;
  assign ds_size         = size_q;
  assign full            = is_full;
  assign empty           = is_empty;
  assign stack_overflow  = ovf_q;
  assign stack_underflow = unf_q;
  assign status          = status_q;

endmodule

// File: tb/tb_param_ds_alu.sv
// Bench for param_ds_alu (WIDTH=16, DEPTH=4): directed vector table, async reset probe,
// then random ops checked against a queue-based stack model.
module tb_param_ds_alu;

  localparam int W  = 16;
  localparam int D  = 4;
  localparam int SW = $clog2(D + 1);

  logic          clk = 1'b0;
  logic          async_reset;
  logic          op_valid;
  logic [2:0]    ds_op;
  logic [2:0]    alu_op;
  logic [W-1:0]  ds_data;
  logic          clr_err;
  logic [W-1:0]  tos_out, nos_out;
  logic [SW-1:0] ds_size;
  logic          full, empty, stack_overflow, stack_underflow;
  logic [3:0]    status;

  param_ds_alu #(.WIDTH(W), .DEPTH(D)) dut (
    .clk             (clk),
    .async_reset     (async_reset),
    .op_valid        (op_valid),
    .ds_op           (ds_op),
    .alu_op          (alu_op),
    .ds_data         (ds_data),
    .clr_err         (clr_err),
    .tos_out         (tos_out),
    .nos_out         (nos_out),
    .ds_size         (ds_size),
    .full            (full),
    .empty           (empty),
    .stack_overflow  (stack_overflow),
    .stack_underflow (stack_underflow),
    .status          (status)
  );

  always #5 clk = ~clk;

  localparam int NOP = 0, PUSH = 1, POP = 2, WRITE = 3, DUP = 4, SWAP = 5, OVER = 6, ALU = 7;
  localparam int ADD = 0, SUB = 1, AND = 2, OR = 3, XOR = 4, NOT = 5, SHL = 6, SHR = 7;

  int n_chk  = 0;
  int n_fail = 0;

  typedef struct {
    bit          v;
    int          op;
    int          aop;
    logic [15:0] d;
    bit          clr;
    logic [15:0] tos;
    logic [15:0] nos;
    int          size;
    bit          ov;
    bit          un;
    logic [3:0]  st;
  } vec_t;

  vec_t tbl[$];

  function automatic vec_t mk(bit v, int op, int aop, logic [15:0] d, bit clr,
                              logic [15:0] tos, logic [15:0] nos, int size,
                              bit ov, bit un, logic [3:0] st);
    vec_t r;
    r.v = v; r.op = op; r.aop = aop; r.d = d; r.clr = clr;
    r.tos = tos; r.nos = nos; r.size = size; r.ov = ov; r.un = un; r.st = st;
    return r;
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic chk_all(string tag, logic [15:0] tos, logic [15:0] nos, int size,
                         bit ov, bit un, logic [3:0] st);
    chk({tag, ".tos"},   32'(tos_out), 32'(tos));
    chk({tag, ".nos"},   32'(nos_out), 32'(nos));
    chk({tag, ".size"},  32'(ds_size), 32'(size));
    chk({tag, ".full"},  32'(full), 32'(size == D));
    chk({tag, ".empty"}, 32'(empty), 32'(size == 0));
    chk({tag, ".ovf"},   32'(stack_overflow), 32'(ov));
    chk({tag, ".unf"},   32'(stack_underflow), 32'(un));
    chk({tag, ".status"}, 32'(status), 32'(st));
  endtask

  task automatic apply(bit v, int op, int aop, logic [15:0] d, bit clr);
    @(negedge clk);
    op_valid = v;
    ds_op    = 3'(op);
    alu_op   = 3'(aop);
    ds_data  = d;
    clr_err  = clr;
    @(posedge clk);
    #1;
  endtask

  // Reference model: a plain queue plus flag bits, results from integer arithmetic.
  logic [15:0] m_stk[$];
  bit          m_ov, m_un;
  logic [3:0]  m_st;

  task automatic m_step(bit v, int op, int aop, logic [15:0] d, bit clr);
    int n = m_stk.size();
    bit eo = 0, eu = 0;
    int ai, bi, sa, sb, s, need;
    bit c, vv;
    logic [15:0] r, t;
    if (clr) begin m_ov = 0; m_un = 0; end
    if (v) begin
      case (op)
        PUSH:  if (n == D) eo = 1; else m_stk.push_back(d);
        POP:   if (n < 1) eu = 1; else void'(m_stk.pop_back());
        WRITE: if (n < 1) eu = 1; else m_stk[n-1] = d;
        DUP: begin
          if (n < 1) eu = 1;
          else if (n == D) eo = 1;
          else m_stk.push_back(m_stk[n-1]);
        end
        SWAP: begin
          if (n < 2) eu = 1;
          else begin t = m_stk[n-1]; m_stk[n-1] = m_stk[n-2]; m_stk[n-2] = t; end
        end
        OVER: begin
          if (n < 2) eu = 1;
          else if (n == D) eo = 1;
          else m_stk.push_back(m_stk[n-2]);
        end
        ALU: begin
          need = (aop < 5) ? 2 : 1;
          if (n < need) eu = 1;
          else begin
            bi = int'(m_stk[n-1]);
            ai = (aop < 5) ? int'(m_stk[n-2]) : 0;
            sb = (bi >= 32768) ? bi - 65536 : bi;
            sa = (ai >= 32768) ? ai - 65536 : ai;
            c = 0; vv = 0;
            case (aop)
              ADD: begin s = ai + bi; c = (s > 65535); vv = (sa + sb > 32767) || (sa + sb < -32768); end
              SUB: begin s = ai - bi; c = (ai < bi);   vv = (sa - sb > 32767) || (sa - sb < -32768); end
              AND: s = ai & bi;
              OR:  s = ai | bi;
              XOR: s = ai ^ bi;
              NOT: s = 65535 - bi;
              SHL: begin s = bi * 2; c = (bi >= 32768); end
              default: begin s = bi / 2; c = (bi % 2) == 1; end
            endcase
            r = 16'(s);
            if (aop < 5) begin void'(m_stk.pop_back()); m_stk[n-2] = r; end
            else m_stk[n-1] = r;
            m_st = {r[15], r == 16'd0, c, vv};
          end
        end
        default: ;
      endcase
    end
    if (eo) m_ov = 1;
    if (eu) m_un = 1;
  endtask

  initial begin
    async_reset = 1'b1;
    op_valid = 1'b0; ds_op = '0; alu_op = '0; ds_data = '0; clr_err = 1'b0;

    #3;
    chk_all("reset", 16'h0, 16'h0, 0, 0, 0, 4'h0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    async_reset = 1'b0;

    //           v  op     aop  data     clr  tos      nos      sz ov un st
    tbl.push_back(mk(1, PUSH,  0,  16'h0005, 0, 16'h0005, 16'h0000, 1, 0, 0, 4'h0));
    tbl.push_back(mk(1, PUSH,  0,  16'h0003, 0, 16'h0003, 16'h0005, 2, 0, 0, 4'h0));
    tbl.push_back(mk(1, ALU,   SUB, 16'h0000, 0, 16'h0002, 16'h0000, 1, 0, 0, 4'h0));
    tbl.push_back(mk(1, POP,   0,  16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 4'h0));
    tbl.push_back(mk(1, PUSH,  0,  16'h0003, 0, 16'h0003, 16'h0000, 1, 0, 0, 4'h0));
    tbl.push_back(mk(1, PUSH,  0,  16'h0005, 0, 16'h0005, 16'h0003, 2, 0, 0, 4'h0));
    tbl.push_back(mk(1, ALU,   SUB, 16'h0000, 0, 16'hFFFE, 16'h0000, 1, 0, 0, 4'hA));
    tbl.push_back(mk(1, POP,   0,  16'h0000, 0, 16'h0000, 16'h0000, 0, 0, 0, 4'hA));
    tbl.push_back(mk(1, PUSH,  0,  16'h7FFF, 0, 16'h7FFF, 16'h0000, 1, 0, 0, 4'hA));
    tbl.push_back(mk(1, PUSH,  0,  16'h0001, 0, 16'h0001, 16'h7FFF, 2, 0, 0, 4'hA));
    tbl.push_back(mk(1, ALU,   ADD, 16'h0000, 0, 16'h8000, 16'h0000, 1, 0, 0, 4'h9));
    tbl.push_back(mk(1, PUSH,  0,  16'h0001, 0, 16'h0001, 16'h8000, 2, 0, 0, 4'h9));
    tbl.push_back(mk(1, PUSH,  0,  16'h0002, 0, 16'h0002, 16'h0001, 3, 0, 0, 4'h9));
    tbl.push_back(mk(1, PUSH,  0,  16'h0003, 0, 16'h0003, 16'h0002, 4, 0, 0, 4'h9));
    tbl.push_back(mk(1, DUP,   0,  16'h0000, 0, 16'h0003, 16'h0002, 4, 1, 0, 4'h9));
    tbl.push_back(mk(0, PUSH,  0,  16'h00AA, 1, 16'h0003, 16'h0002, 4, 0, 0, 4'h9));
    tbl.push_back(mk(1, ALU,   XOR, 16'h0000, 0, 16'h0001, 16'h0001, 3, 0, 0, 4'h0));
    tbl.push_back(mk(1, ALU,   AND, 16'h0000, 0, 16'h0001, 16'h8000, 2, 0, 0, 4'h0));
    tbl.push_back(mk(1, ALU,   NOT, 16'h0000, 0, 16'hFFFE, 16'h8000, 2, 0, 0, 4'h8));
    tbl.push_back(mk(1, ALU,   SHL, 16'h0000, 0, 16'hFFFC, 16'h8000, 2, 0, 0, 4'hA));
    tbl.push_back(mk(1, ALU,   SHR, 16'h0000, 0, 16'h7FFE, 16'h8000, 2, 0, 0, 4'h0));
    tbl.push_back(mk(1, ALU,   OR,  16'h0000, 0, 16'hFFFE, 16'h0000, 1, 0, 0, 4'h8));
    tbl.push_back(mk(1, ALU,   SUB, 16'h0000, 0, 16'hFFFE, 16'h0000, 1, 0, 1, 4'h8));
    tbl.push_back(mk(1, SWAP,  0,  16'h0000, 0, 16'hFFFE, 16'h0000, 1, 0, 1, 4'h8));
    tbl.push_back(mk(1, POP,   0,  16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 0, 4'h8));
    tbl.push_back(mk(1, POP,   0,  16'h0000, 1, 16'h0000, 16'h0000, 0, 0, 1, 4'h8));
    tbl.push_back(mk(1, PUSH,  0,  16'h0009, 0, 16'h0009, 16'h0000, 1, 0, 1, 4'h8));
    tbl.push_back(mk(1, SWAP,  0,  16'h0000, 0, 16'h0009, 16'h0000, 1, 0, 1, 4'h8));
    tbl.push_back(mk(1, PUSH,  0,  16'h0000, 0, 16'h0000, 16'h0009, 2, 0, 1, 4'h8));
    tbl.push_back(mk(1, ALU,   ADD, 16'h0000, 0, 16'h0009, 16'h0000, 1, 0, 1, 4'h0));
    tbl.push_back(mk(1, WRITE, 0,  16'h0004, 0, 16'h0004, 16'h0000, 1, 0, 1, 4'h0));
    tbl.push_back(mk(1, DUP,   0,  16'h0000, 0, 16'h0004, 16'h0004, 2, 0, 1, 4'h0));
    tbl.push_back(mk(1, ALU,   SUB, 16'h0000, 1, 16'h0000, 16'h0000, 1, 0, 0, 4'h4));
    tbl.push_back(mk(1, OVER,  0,  16'h0000, 0, 16'h0000, 16'h0000, 1, 0, 1, 4'h4));
    tbl.push_back(mk(1, PUSH,  0,  16'h0001, 0, 16'h0001, 16'h0000, 2, 0, 1, 4'h4));
    tbl.push_back(mk(1, PUSH,  0,  16'h0002, 0, 16'h0002, 16'h0001, 3, 0, 1, 4'h4));
    tbl.push_back(mk(1, SWAP,  0,  16'h0000, 0, 16'h0001, 16'h0002, 3, 0, 1, 4'h4));
    tbl.push_back(mk(1, OVER,  0,  16'h0000, 0, 16'h0002, 16'h0001, 4, 0, 1, 4'h4));
    tbl.push_back(mk(1, PUSH,  0,  16'h0007, 0, 16'h0002, 16'h0001, 4, 1, 1, 4'h4));
    tbl.push_back(mk(1, NOP,   0,  16'h1234, 0, 16'h0002, 16'h0001, 4, 1, 1, 4'h4));

    foreach (tbl[i]) begin
      apply(tbl[i].v, tbl[i].op, tbl[i].aop, tbl[i].d, tbl[i].clr);
      $display("vec %0d: v=%0d op=%0d alu=%0d d=%h clr=%0d -> tos=%h nos=%h size=%0d ovf=%0d unf=%0d st=%h",
               i, tbl[i].v, tbl[i].op, tbl[i].aop, tbl[i].d, tbl[i].clr,
               tos_out, nos_out, ds_size, stack_overflow, stack_underflow, status);
      chk_all($sformatf("vec%0d", i), tbl[i].tos, tbl[i].nos, tbl[i].size,
              tbl[i].ov, tbl[i].un, tbl[i].st);
    end

    // Asynchronous reset mid-cycle must clear everything before the next edge.
    @(negedge clk);
    op_valid = 1'b0;
    clr_err  = 1'b0;
    @(posedge clk);
    #2;
    async_reset = 1'b1;
    #1;
    $display("async reset mid-cycle -> tos=%h size=%0d ovf=%0d unf=%0d st=%h",
             tos_out, ds_size, stack_overflow, stack_underflow, status);
    chk_all("async_rst", 16'h0, 16'h0, 0, 0, 0, 4'h0);
    @(negedge clk);
    async_reset = 1'b0;

    // Contents must be gone: DUP on the freshly reset stack underflows.
    apply(1, DUP, 0, 16'h0, 0);
    $display("post-reset dup -> size=%0d unf=%0d", ds_size, stack_underflow);
    chk_all("post_rst_dup", 16'h0, 16'h0, 0, 0, 1, 4'h0);
    apply(0, NOP, 0, 16'h0, 1);

    m_stk.delete();
    m_ov = 0; m_un = 0; m_st = 4'h0;
    for (int k = 0; k < 400; k++) begin
      bit          rv, rc;
      int          rop, raop;
      logic [15:0] rd;
      logic [15:0] etos, enos;
      int          n;
      rv   = ($urandom_range(0, 9) != 0);
      rc   = ($urandom_range(0, 9) == 0);
      rop  = $urandom_range(0, 7);
      raop = $urandom_range(0, 7);
      case ($urandom_range(0, 5))
        0: rd = 16'h7FFF;
        1: rd = 16'h8000;
        2: rd = 16'hFFFF;
        3: rd = 16'h0000;
        default: rd = 16'($urandom);
      endcase
      apply(rv, rop, raop, rd, rc);
      m_step(rv, rop, raop, rd, rc);
      n    = m_stk.size();
      etos = (n >= 1) ? m_stk[n-1] : 16'h0;
      enos = (n >= 2) ? m_stk[n-2] : 16'h0;
      $display("rnd %0d: v=%0d op=%0d alu=%0d d=%h clr=%0d -> tos=%h nos=%h size=%0d ovf=%0d unf=%0d st=%h",
               k, rv, rop, raop, rd, rc, tos_out, nos_out, ds_size,
               stack_overflow, stack_underflow, status);
      chk_all($sformatf("rnd%0d", k), etos, enos, n, m_ov, m_un, m_st);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
